inst_seg_scan: RTL and testbench
================================

Name: inst_seg_scan

Overview:
- Downstream consumer of the instruction-memory read port; shows the 32-bit instruction word just fetched as 8 hex digits on the board's multiplexed 7-segment display.
- Captures the word through a valid strobe into a shadow register. Commits it to the display only at a frame boundary, so the display never tears.
- Time-multiplexes the 8 anodes with a programmable refresh divider.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays lit; legal range 1..2^20.
- BLANK_LEADING, 1: 1 = blank leading zero digits (digit 0 is always shown); 0 = show all 8 digits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ena  in  1  display enable; 0 = all digits dark.
- data_valid  in  1  one-cycle strobe; data is a new instruction word.
- data  in  32  instruction word from the instruction memory read port.
- seg  out  7  cathodes, active-low, seg[6:0] = {g,f,e,d,c,b,a}.
- ans  out  8  anodes, active-low; ans[i] drives digit i, where digit 0 is rightmost and shows data[3:0].
- frame_done  out  1  one-cycle pulse when digit 7's slot ends.

Behaviour:
- Reset (reset=0, async), all registers cleared:
  - div_cnt=0, idx=0, disp=0, shadow=0, pending=0.
  - seg=7'b1111111, ans=8'hFF, frame_done=0.
- Divider and tick:
  - div_cnt counts 0..REFRESH_DIV-1, then wraps.
  - tick=1 in the cycle where div_cnt==REFRESH_DIV-1. With REFRESH_DIV=1, tick fires every cycle.
- Digit index: on tick, idx advances by 1 mod 8.
- Frame boundary (tick with idx==7):
  - idx goes to 0 and frame_done=1 for the next cycle only.
  - If pending=1, disp<=shadow and pending<=0.
- Capture: data_valid=1 gives shadow<=data and pending<=1 on the same edge.
- Capture coinciding with a frame boundary:
  - The commit uses the shadow value held before that edge.
  - The new data lands in shadow, and pending stays 1, so the new word commits at the following boundary.
- Back-to-back data_valid: the last word before a boundary wins; earlier words are dropped silently.
- Digit decode: nibble n = disp[4*idx+3 : 4*idx], hex table active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blanking: the digit is blanked (ans=8'hFF, seg=7'b1111111) when BLANK_LEADING=1, idx!=0, and disp[31:4*idx]==0.
- Anode select otherwise: ans = ~(8'b1 << idx).
- Output timing: seg and ans are registered and reflect idx/disp one clock after they change.
- ena=0:
  - div_cnt and idx are held at 0, seg=7F, ans=FF, frame_done=0.
  - Capture still works.
  - A pending word commits immediately, next edge, since the display is dark.
- ena 0->1: scanning starts at digit 0, with a full REFRESH_DIV slot.
- Latency: a word strobed during a frame is visible on digit 0 at the boundary edge+1 clk. Worst case from strobe to first display is 8*REFRESH_DIV+1 cycles.
- Reset mid-scan: all state clears immediately; the pending word is lost.

Test Plan:
- REFRESH_DIV=4, BLANK_LEADING=0, ena=1, strobe data=32'h12345678, wait one frame:
  - after the next boundary, digit 0 shows seg=0000000 ('8'), ans=FE;
  - 4 clocks later ans=FD with seg=1111000 ('7');
  - digit 7 shows '1'; frame_done pulses once every 32 clocks.
- Tearing check: strobe 32'hFFFFFFFF mid-frame while disp=32'h0:
  - all digits keep showing '0' until the boundary;
  - then every digit shows 0001110 ('F'), never mixed within a frame.
- Coincident events: strobe 32'hAAAAAAAA exactly on the boundary tick while shadow=32'h11111111, pending=1:
  - the next frame shows all '1';
  - the frame after that shows all 'A' (0001000).
- BLANK_LEADING=1, data=32'h0000000C:
  - digit 0 shows 1000110 with ans=FE;
  - digits 1..7 give ans=FF, seg=7F.
  - data=32'h0: digit 0 shows '0' and all other slots are dark.
- ena=0 then strobe 32'hDEADBEEF:
  - seg=7F, ans=FF throughout;
  - after ena=1, the first slot shows digit 0 'F' (0001110) with no boundary wait.
- Assert reset=0 mid-frame, asynchronously between clock edges:
  - seg=7F, ans=FF, frame_done=0 immediately;
  - after release, the display shows 0 or blank and the previous pending word is not displayed.

Source files
------------

// File: rtl/inst_seg_scan.sv
// inst_seg_scan: tear-free 8-digit hex display of the last fetched instruction word
module inst_seg_scan #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic        data_valid,
    input  logic [31:0] data,
    output logic [6:0]  seg,
    output logic [7:0]  ans,
    output logic        frame_done
);
    localparam int DW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [31:0]   disp;
    logic [31:0]   shadow;
    logic          pending;
    logic          tick;
    logic          boundary;
    logic          commit;
    logic          blank;
    logic [3:0]    nib;
    logic [6:0]    hex;

    assign tick     = ena && div_cnt == DIV_MAX;
    assign boundary = tick && idx == 3'd7;
    // while dark there is nothing to tear, so a pending word goes straight in
    assign commit   = pending && (boundary || !ena);
    assign nib      = disp[{idx, 2'b00} +: 4];
    assign blank    = BLANK_LEADING && idx != 3'd0 && (disp >> {idx, 2'b00}) == 32'd0;

    // hex digit to active-low {g,f,e,d,c,b,a}
    always_comb begin
        hex = 7'b1111111;
        case (nib)
            4'h0: hex = 7'b1000000;
            4'h1: hex = 7'b1111001;
            4'h2: hex = 7'b0100100;
            4'h3: hex = 7'b0110000;
            4'h4: hex = 7'b0011001;
            4'h5: hex = 7'b0010010;
            4'h6: hex = 7'b0000010;
            4'h7: hex = 7'b1111000;
            4'h8: hex = 7'b0000000;
            4'h9: hex = 7'b0010000;
            4'hA: hex = 7'b0001000;
            4'hB: hex = 7'b0000011;
            4'hC: hex = 7'b1000110;
            4'hD: hex = 7'b0100001;
            4'hE: hex = 7'b0000110;
            default: hex = 7'b0001110;
        endcase
    end

    // refresh divider and digit scan, parked at digit 0 while disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt    <= '0;
            idx        <= 3'd0;
            frame_done <= 1'b0;
        end else begin
            div_cnt    <= (!ena || tick) ? '0 : div_cnt + 1'b1;
            idx        <= !ena ? 3'd0 : idx + {2'b00, tick};
            frame_done <= boundary;
        end
    end

    // capture into shadow; commit to the displayed word only at frame edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow  <= 32'd0;
            pending <= 1'b0;
            disp    <= 32'd0;
        end else begin
            if (data_valid) shadow <= data;
            if (commit) disp <= shadow;
            pending <= data_valid || (pending && !commit);
        end
    end

    // registered cathode/anode drive for the digit currently selected
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= 7'b1111111;
            ans <= 8'hFF;
        end else begin
            seg <= (!ena || blank) ? 7'b1111111 : hex;
            ans <= (!ena || blank) ? 8'hFF : ~(8'b1 << idx);
        end
    end
endmodule

// File: tb/tb_inst_seg_scan.sv
// tb_inst_seg_scan: frame-level scoreboard check of both blanking modes
module tb_inst_seg_scan;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ena = 1'b1;
    logic        data_valid = 1'b0;
    logic [31:0] data = 32'd0;
    logic [6:0]  seg0, seg1;
    logic [7:0]  ans0, ans1;
    logic        fd0, fd1;

    int nvec = 0;
    int nmis = 0;
    int fnum = 0;
    logic [31:0] exp_q[$];
    logic [14:0] got0 [8];

    logic [6:0] hexseg [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [31:0] data;
        logic [6:0]  s0;
        logic [6:0]  s7;
    } vec_t;
    vec_t vt [6];

    inst_seg_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u0 (
        .clk(clk), .reset(reset), .ena(ena), .data_valid(data_valid), .data(data),
        .seg(seg0), .ans(ans0), .frame_done(fd0)
    );
    inst_seg_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u1 (
        .clk(clk), .reset(reset), .ena(ena), .data_valid(data_valid), .data(data),
        .seg(seg1), .ans(ans1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [14:0] model(logic [31:0] w, int d, bit bl);
        int hi = 0;
        logic [7:0] one = 8'd1;
        for (int k = 0; k < 8; k++) if (w[4*k +: 4] != 4'd0) hi = k;
        if (bl && d > hi) return {8'hFF, 7'h7F};
        return {~(one << d), hexseg[w[4*d +: 4]]};
    endfunction

    task automatic chk_dark(string tag);
        chk($sformatf("%s_u0", tag), {16'd0, fd0, ans0, seg0}, {16'd0, 1'b0, 8'hFF, 7'h7F});
        chk($sformatf("%s_u1", tag), {16'd0, fd1, ans1, seg1}, {16'd0, 1'b0, 8'hFF, 7'h7F});
    endtask

    // waits for a boundary, then checks all 8 slots of the following frame;
    // optional strobes at cycle offsets sa/sb (capture edge = offset+1 after frame start)
    task automatic check_frame(int sa, logic [31:0] da, int sb, logic [31:0] db);
        logic [31:0] w;
        logic fd_bad = 1'b0;
        int n = 0;
        int d;
        while (!fd0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("frame%0d_wait", fnum), {31'd0, fd0}, 32'd1);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            w = 32'd0;
        end else w = exp_q.pop_front();
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            data_valid = (c == sa) || (c == sb);
            data = (c == sb) ? db : da;
            if (c % 4 == 0) begin
                d = c / 4;
                got0[d] = {ans0, seg0};
                chk($sformatf("frame%0d_d%0d_u0", fnum, d), {17'd0, ans0, seg0}, {17'd0, model(w, d, 1'b0)});
                chk($sformatf("frame%0d_d%0d_u1", fnum, d), {17'd0, ans1, seg1}, {17'd0, model(w, d, 1'b1)});
            end
            if (c < 31) fd_bad = fd_bad | fd0 | fd1;
        end
        data_valid = 1'b0;
        chk($sformatf("frame%0d_fd_width", fnum), {31'd0, fd_bad}, 32'd0);
        chk($sformatf("frame%0d_fd_period", fnum), {30'd0, fd0, fd1}, 32'd3);
        fnum++;
    endtask

    initial begin
        logic [31:0] prev;
        vt[0] = '{32'h12345678, 7'b0000000, 7'b1111001};
        vt[1] = '{32'h0000000C, 7'b1000110, 7'b1000000};
        vt[2] = '{32'h00000000, 7'b1000000, 7'b1000000};
        vt[3] = '{32'hDEADBEEF, 7'b0001110, 7'b0100001};
        vt[4] = '{32'h0010000C, 7'b1000110, 7'b1000000};
        vt[5] = '{32'h9ABCDEF0, 7'b1000000, 7'b0010000};

        repeat (3) @(negedge clk);
        chk_dark("reset");
        reset = 1'b1;

        exp_q.push_back(32'h0);
        check_frame(-1, 32'h0, -1, 32'h0);
        // tearing: strobe mid-frame, current frame must stay all zero
        exp_q.push_back(32'h0);
        check_frame(13, 32'hFFFFFFFF, -1, 32'h0);
        exp_q.push_back(32'hFFFFFFFF);
        check_frame(5, 32'h11111111, 30, 32'hAAAAAAAA);
        // strobe coincident with the boundary commits the older shadow first
        exp_q.push_back(32'h11111111);
        check_frame(-1, 32'h0, -1, 32'h0);
        exp_q.push_back(32'hAAAAAAAA);
        check_frame(2, 32'h0BADF00D, 10, 32'h12345678);
        exp_q.push_back(32'h12345678);
        check_frame(-1, 32'h0, -1, 32'h0);

        prev = 32'h12345678;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(prev);
            check_frame(4, vt[i].data, -1, 32'h0);
            exp_q.push_back(vt[i].data);
            check_frame(-1, 32'h0, -1, 32'h0);
            chk($sformatf("vec%0d_digit0", i), {17'd0, got0[0]}, {17'd0, 8'hFE, vt[i].s0});
            chk($sformatf("vec%0d_digit7", i), {17'd0, got0[7]}, {17'd0, 8'h7F, vt[i].s7});
            prev = vt[i].data;
        end

        // disabled: dark throughout, capture still commits immediately
        ena = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            data_valid = (k == 2);
            data = 32'hDEADBEEF;
            chk_dark($sformatf("ena0_c%0d", k));
        end
        data_valid = 1'b0;
        ena = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("ena1_c%0d", k), {17'd0, ans0, seg0},
                k < 4 ? {17'd0, 8'hFE, 7'b0001110} : {17'd0, 8'hFD, 7'b0000110});
        end
        exp_q.push_back(32'hDEADBEEF);
        check_frame(30, 32'h12345678, -1, 32'h0);

        // async reset between edges with a word still pending
        #2 reset = 1'b0;
        #1 chk_dark("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(32'h0);
        check_frame(-1, 32'h0, -1, 32'h0);
        exp_q.push_back(32'h0);
        check_frame(-1, 32'h0, -1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
